spi_master_module: RTL and testbench

SPI master (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) that drives `ncs`/`sck`/`mosi` and samples `miso`. It is the initiator-side counterpart of the team's SPI slave function block: on-chip logic hands it one byte per request and receives the byte shifted in from the slave. It can hold chip-select low across consecutive bytes for multi-byte transactions.

---
 rtl/spi_master_module.sv | 154 +++++++++++++++
 tb/tb_spi_master_module.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_module.sv
// SPI mode-0 master: 8-bit MSB-first frames on ncs/sck/mosi, miso captured through a 2-flop synchronizer.
// Handshake: ICall is a request taken only while OBusy=0 (never queued); ODone pulses one cycle with OData valid.
module spi_master_module #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ICall,
    input  logic [7:0] IData,
    input  logic       IHold,
    output logic       OBusy,
    output logic [7:0] OData,
    output logic       ODone,
    output logic       ncs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_HIGH = 3'd2,
        S_LOW  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       done_q;
    logic       hold_q;
    logic       miso_meta;
    logic       miso_s;

    logic div_last;
    logic gap_last;
    logic accept;
    logic sample;
    logic frame_end;

    // div_cnt times both the sck half-periods and the chip-select gap.
    assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
    assign gap_last  = (div_cnt == 8'(CS_GAP - 1));
    assign accept    = (state == S_IDLE) && ICall;
    assign sample    = (state == S_HIGH) && div_last;
    assign frame_end = (state == S_LOW) && div_last && (bit_cnt == 3'd7);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (ICall) begin
                    state_nx = S_LEAD;
                end else if (hold_q && !IHold) begin
                    state_nx = S_GAP;
                end
            end
            S_LEAD: if (div_last) state_nx = S_HIGH;
            S_HIGH: if (div_last) state_nx = S_LOW;
            S_LOW: begin
                if (div_last) begin
                    state_nx = (bit_cnt == 3'd7) ? S_GAP : S_HIGH;
                end
            end
            S_GAP: begin
                // The ODone cycle is the first GAP cycle; IHold there keeps the slave selected.
                if (done_q && IHold) begin
                    state_nx = S_IDLE;
                end else if (gap_last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            tx_sr     <= 8'd0;
            rx_sr     <= 8'd0;
            OData     <= 8'd0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_s    <= miso_meta;
            div_cnt   <= (state_nx != state || state == S_IDLE) ? 8'd0 : div_cnt + 8'd1;
            if (accept) begin
                tx_sr   <= IData;
                rx_sr   <= 8'd0;
                bit_cnt <= 3'd0;
            end else begin
                if (sample) begin
                    rx_sr <= {rx_sr[6:0], miso_s};
                    // Bit 0 stays on mosi through the final LOW phase.
                    if (bit_cnt != 3'd7) begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
                if (state == S_LOW && div_last) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            done_q <= frame_end;
            if (frame_end) begin
                OData <= rx_sr;
            end
            if (state == S_IDLE && (ICall || !IHold)) begin
                hold_q <= 1'b0;
            end else if (state == S_GAP && done_q && IHold) begin
                hold_q <= 1'b1;
            end
        end
    end

    always_comb begin
        OBusy = (state != S_IDLE);
        ODone = done_q;
        sck   = 1'b0;
        mosi  = tx_sr[7];
        ncs   = 1'b1;
        case (state)
            S_IDLE: ncs = !hold_q;
            S_LEAD: ncs = 1'b0;
            S_HIGH: begin
                ncs = 1'b0;
                sck = 1'b1;
            end
            S_LOW:  ncs = 1'b0;
            S_GAP:  ncs = !(done_q && IHold);
            default: ncs = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_spi_master_module.sv
// Bench for spi_master_module: default instance (D=4, gap 4) plus a fast instance (D=3, gap 1).
module tb_spi_master_module;

    localparam int D  = 4;
    localparam int D3 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ICall, IHold, ICall3;
    logic [7:0] IData, IData3;
    logic       OBusy, ODone, ncs, sck, mosi, miso;
    logic [7:0] OData;
    logic [2:0] state_dbg;
    logic       OBusy3, ODone3, ncs3, sck3, mosi3, miso3;
    logic [7:0] OData3;
    logic [2:0] state_dbg3;

    logic       loop_en;
    logic [7:0] slave_byte;
    logic [2:0] sfall;

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // Mode-0 slave: presents MSB on select, advances one bit per sck falling edge.
    always @(negedge sck or posedge ncs) begin
        if (ncs) sfall <= 3'd0;
        else     sfall <= sfall + 3'd1;
    end
    assign miso  = loop_en ? mosi : slave_byte[3'd7 - sfall];
    assign miso3 = mosi3;

    spi_master_module #(.CLK_DIV(D), .CS_GAP(4)) u_dut (
        .clk(clk), .rst(rst), .ICall(ICall), .IData(IData), .IHold(IHold),
        .OBusy(OBusy), .OData(OData), .ODone(ODone), .ncs(ncs), .sck(sck),
        .mosi(mosi), .miso(miso), .state_dbg(state_dbg)
    );

    spi_master_module #(.CLK_DIV(D3), .CS_GAP(1)) u_dut3 (
        .clk(clk), .rst(rst), .ICall(ICall3), .IData(IData3), .IHold(1'b0),
        .OBusy(OBusy3), .OData(OData3), .ODone(ODone3), .ncs(ncs3), .sck(sck3),
        .mosi(mosi3), .miso(miso3), .state_dbg(state_dbg3)
    );

    // Raise ICall in the negedge of cycle 0 so the following posedge accepts it.
    task automatic start(input logic [7:0] d);
        @(negedge clk);
        IData = d;
        ICall = 1'b1;
    endtask

    task automatic start3(input logic [7:0] d);
        @(negedge clk);
        IData3 = d;
        ICall3 = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({ncs, sck, mosi, OBusy, ODone, OData, state_dbg} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: got ncs,sck,mosi,busy,done,data,state=%b %b %b %b %b %h %0d want 1 0 0 0 0 00 0",
                     ncs, sck, mosi, OBusy, ODone, OData, state_dbg);
        end
        n_cmp++;
        if ({ncs3, sck3, mosi3, OBusy3, ODone3, OData3} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state_d3: got %b %b %b %b %b %h want 1 0 0 0 0 00",
                     ncs3, sck3, mosi3, OBusy3, ODone3, OData3);
        end
    endtask

    task automatic test_loopback();
        int         sck_err = 0, ncs_err = 0, done_n = 0, done_at = -1;
        logic [7:0] mosi_b = 8'h00;
        logic [7:0] exp_b;
        logic       exp_sck, exp_ncs;
        logic       b72 = 1'b0, b73 = 1'b1;
        loop_en = 1'b1;
        IHold   = 1'b0;
        start(8'hA5);
        exp_q.push_back(8'hA5);
        for (int r = 1; r <= 80; r++) begin
            @(negedge clk);
            if (r == 1) ICall = 1'b0;
            exp_sck = (r > D) && (r <= 17*D) && (((r-1-D)/D) % 2 == 0);
            exp_ncs = !(r <= 17*D);
            if (sck !== exp_sck) sck_err++;
            if (ncs !== exp_ncs) ncs_err++;
            if ((r > D) && ((r-1-D) % (2*D) == 0) && (r <= 16*D)) mosi_b = {mosi_b[6:0], mosi};
            if (r == 72) b72 = OBusy;
            if (r == 73) b73 = OBusy;
            if (ODone === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = r;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL loopback_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData !== exp_b) begin
                        n_err++;
                        $display("FAIL loopback_data: got %h want %h", OData, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (sck_err !== 0)    begin n_err++; $display("FAIL loopback_sck: %0d wrong sck cycles, want 0", sck_err); end
        n_cmp++; if (ncs_err !== 0)    begin n_err++; $display("FAIL loopback_ncs: %0d wrong ncs cycles, want 0", ncs_err); end
        n_cmp++; if (mosi_b !== 8'hA5) begin n_err++; $display("FAIL loopback_mosi: got %h want a5", mosi_b); end
        n_cmp++; if (done_at !== 69)   begin n_err++; $display("FAIL loopback_done_cycle: got %0d want 69", done_at); end
        n_cmp++; if (done_n !== 1)     begin n_err++; $display("FAIL loopback_done_count: got %0d want 1", done_n); end
        n_cmp++; if (b72 !== 1'b1)     begin n_err++; $display("FAIL loopback_busy72: got %b want 1", b72); end
        n_cmp++; if (b73 !== 1'b0)     begin n_err++; $display("FAIL loopback_busy73: got %b want 0", b73); end
        exp_q.delete();
    endtask

    task automatic test_ignore_busy();
        int         mosi_err = 0, done_n = 0;
        int         done_t[2] = '{-1, -1};
        logic [7:0] exp_b;
        logic       b73 = 1'b1, b74 = 1'b0;
        loop_en    = 1'b0;
        slave_byte = 8'h3C;
        start(8'hFF);
        exp_q.push_back(8'h3C);
        for (int r = 1; r <= 150; r++) begin
            @(negedge clk);
            if (r == 1) ICall = 1'b0;
            if (r <= 68 && mosi !== 1'b1) mosi_err++;
            if (r == 72) begin
                ICall = 1'b1;
                IData = 8'h11;
            end
            if (r == 73) begin
                b73 = OBusy;
                slave_byte = 8'hC3;
                exp_q.push_back(8'hC3);
            end
            if (r == 74) begin
                b74 = OBusy;
                ICall = 1'b0;
            end
            if (ODone === 1'b1) begin
                if (done_n < 2) done_t[done_n] = r;
                done_n++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL slave_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData !== exp_b) begin
                        n_err++;
                        $display("FAIL slave_data: got %h want %h", OData, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (mosi_err !== 0)   begin n_err++; $display("FAIL slave_mosi_ones: %0d cycles not 1, want 0", mosi_err); end
        n_cmp++; if (b73 !== 1'b0)     begin n_err++; $display("FAIL busy_call72_ignored: busy at 73 got %b want 0", b73); end
        n_cmp++; if (b74 !== 1'b1)     begin n_err++; $display("FAIL busy_call73_taken: busy at 74 got %b want 1", b74); end
        n_cmp++; if (done_n !== 2)     begin n_err++; $display("FAIL slave_done_count: got %0d want 2", done_n); end
        n_cmp++; if (done_t[1] !== 142) begin n_err++; $display("FAIL slave_second_done: got %0d want 142", done_t[1]); end
        exp_q.delete();
        loop_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int         ncs_err = 0, done_n = 0;
        int         done_t[2] = '{-1, -1};
        logic [7:0] exp_b;
        logic       b70 = 1'b1, b71 = 1'b0, n142 = 1'b0, b145 = 1'b0, b146 = 1'b1;
        loop_en = 1'b1;
        IHold   = 1'b1;
        start(8'h01);
        exp_q.push_back(8'h01);
        for (int r = 1; r <= 150; r++) begin
            @(negedge clk);
            if (r == 1) ICall = 1'b0;
            if (r <= 141 && ncs !== 1'b0) ncs_err++;
            if (r == 70) begin
                b70 = OBusy;
                ICall = 1'b1;
                IData = 8'h80;
                exp_q.push_back(8'h80);
            end
            if (r == 71) begin
                b71 = OBusy;
                ICall = 1'b0;
            end
            if (r == 141) IHold = 1'b0;
            if (r == 142) n142 = ncs;
            if (r == 145) b145 = OBusy;
            if (r == 146) b146 = OBusy;
            if (ODone === 1'b1) begin
                if (done_n < 2) done_t[done_n] = r;
                done_n++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL hold_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData !== exp_b) begin
                        n_err++;
                        $display("FAIL hold_data: got %h want %h", OData, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (ncs_err !== 0)     begin n_err++; $display("FAIL hold_ncs_low: %0d cycles high, want 0", ncs_err); end
        n_cmp++; if (b70 !== 1'b0)      begin n_err++; $display("FAIL hold_busy70: got %b want 0", b70); end
        n_cmp++; if (b71 !== 1'b1)      begin n_err++; $display("FAIL hold_busy71: got %b want 1", b71); end
        n_cmp++; if (done_n !== 2)      begin n_err++; $display("FAIL hold_done_count: got %0d want 2", done_n); end
        n_cmp++; if (done_t[0] !== 69 || done_t[1] !== 139)
            begin n_err++; $display("FAIL hold_done_cycles: got %0d,%0d want 69,139", done_t[0], done_t[1]); end
        n_cmp++; if (n142 !== 1'b1)     begin n_err++; $display("FAIL hold_release_ncs: got %b want 1", n142); end
        n_cmp++; if (b145 !== 1'b1 || b146 !== 1'b0)
            begin n_err++; $display("FAIL hold_gap: busy at 145,146 got %b,%b want 1,0", b145, b146); end
        exp_q.delete();
    endtask

    task automatic test_call_held();
        int         busy_err = 0, done_n = 0;
        logic [7:0] exp_b;
        loop_en = 1'b1;
        IHold   = 1'b0;
        start(8'h3C);
        exp_q.push_back(8'h3C);
        for (int r = 1; r <= 100; r++) begin
            @(negedge clk);
            if (r == 73) ICall = 1'b0;
            if (OBusy !== (r <= 72)) busy_err++;
            if (ODone === 1'b1) begin
                done_n++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL held_call_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData !== exp_b) begin
                        n_err++;
                        $display("FAIL held_call_data: got %h want %h", OData, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (busy_err !== 0) begin n_err++; $display("FAIL held_call_busy: %0d wrong busy cycles, want 0", busy_err); end
        n_cmp++; if (done_n !== 1)   begin n_err++; $display("FAIL held_call_frames: got %0d want 1", done_n); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int         done_n = 0, done_at = -1;
        logic [7:0] exp_b;
        logic       b29 = 1'b0;
        loop_en = 1'b1;
        IHold   = 1'b0;
        start(8'h5A);
        for (int r = 1; r <= 110; r++) begin
            @(negedge clk);
            if (r == 1) ICall = 1'b0;
            if (r == 29) b29 = OBusy;
            if (r == 30) begin
                rst = 1'b1;
                #1;
                n_cmp++;
                if ({ncs, sck, mosi, OBusy, ODone, OData} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
                    n_err++;
                    $display("FAIL midreset_outputs: got ncs,sck,mosi,busy,done,data=%b %b %b %b %b %h want 1 0 0 0 0 00",
                             ncs, sck, mosi, OBusy, ODone, OData);
                end
            end
            if (r == 33) rst = 1'b0;
            if (ODone === 1'b1) done_n++;
        end
        n_cmp++; if (b29 !== 1'b1)    begin n_err++; $display("FAIL midreset_busy_before: got %b want 1", b29); end
        n_cmp++; if (done_n !== 0)    begin n_err++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_n); end
        n_cmp++; if (OData !== 8'h00) begin n_err++; $display("FAIL midreset_odata: got %h want 00", OData); end
        start(8'h96);
        exp_q.push_back(8'h96);
        done_n = 0;
        for (int r = 1; r <= 75; r++) begin
            @(negedge clk);
            if (r == 1) ICall = 1'b0;
            if (ODone === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = r;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL midreset_next_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData !== exp_b) begin
                        n_err++;
                        $display("FAIL midreset_next_data: got %h want %h", OData, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (done_at !== 69 || done_n !== 1)
            begin n_err++; $display("FAIL midreset_next_frame: done at %0d count %0d want 69 1", done_at, done_n); end
        exp_q.delete();
    endtask

    task automatic test_div3();
        int         sck_err = 0, done_n = 0;
        int         done_t[2] = '{-1, -1};
        logic [7:0] exp_b;
        logic       exp_sck;
        logic       b52 = 1'b0, b53 = 1'b1, b54 = 1'b0;
        start3(8'hC7);
        exp_q.push_back(8'hC7);
        for (int r = 1; r <= 110; r++) begin
            @(negedge clk);
            if (r == 1) ICall3 = 1'b0;
            if (r <= 52) begin
                exp_sck = (r > D3) && (r <= 17*D3) && (((r-1-D3)/D3) % 2 == 0);
                if (sck3 !== exp_sck) sck_err++;
            end
            if (r == 52) b52 = OBusy3;
            if (r == 53) begin
                b53 = OBusy3;
                ICall3 = 1'b1;
                IData3 = 8'h2B;
                exp_q.push_back(8'h2B);
            end
            if (r == 54) begin
                b54 = OBusy3;
                ICall3 = 1'b0;
            end
            if (ODone3 === 1'b1) begin
                if (done_n < 2) done_t[done_n] = r;
                done_n++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL div3_data: ODone at cycle %0d with nothing expected", r);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (OData3 !== exp_b) begin
                        n_err++;
                        $display("FAIL div3_data: got %h want %h", OData3, exp_b);
                    end
                end
            end
        end
        n_cmp++; if (sck_err !== 0) begin n_err++; $display("FAIL div3_sck: %0d wrong sck cycles, want 0", sck_err); end
        n_cmp++; if (done_t[0] !== 52 || done_t[1] !== 105)
            begin n_err++; $display("FAIL div3_done_cycles: got %0d,%0d want 52,105", done_t[0], done_t[1]); end
        n_cmp++; if ({b52, b53, b54} !== 3'b101)
            begin n_err++; $display("FAIL div3_busy: busy at 52,53,54 got %b%b%b want 101", b52, b53, b54); end
        exp_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        ICall      = 1'b0;
        IData      = 8'h00;
        IHold      = 1'b0;
        ICall3     = 1'b0;
        IData3     = 8'h00;
        loop_en    = 1'b1;
        slave_byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_loopback();
        test_ignore_busy();
        test_back_to_back();
        test_call_held();
        test_reset_mid();
        test_div3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
